// File: rtl/ctrl_seq_if.sv
// Bus bundle between ctrl_seq and its instruction memory, data memory, register file and ALU.
// master is the sequencer side; slave is the side holding memories, register file and ALU.
interface ctrl_seq_if;
  logic [31:0] Read_PC;
  logic [31:0] Instruction;
  logic        Op2En;
  logic        Op2RW;
  logic        M_Clear;
  logic [31:0] R_W_Addr;
  logic [31:0] DataWrite;
  logic [31:0] DataRead;
  logic [1:0]  src_1;
  logic [1:0]  src_2;
  logic [31:0] data_src_1;
  logic [31:0] data_src_2;
  logic        opwrite;
  logic [1:0]  reg_write;
  logic [31:0] data;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [3:0]  op;
  logic [31:0] rd;

  modport master (
    output Read_PC, Op2En, Op2RW, M_Clear, R_W_Addr, DataWrite,
           src_1, src_2, opwrite, reg_write, data, rs, rt, op,
    input  Instruction, DataRead, data_src_1, data_src_2, rd
  );

  modport slave (
    input  Read_PC, Op2En, Op2RW, M_Clear, R_W_Addr, DataWrite,
           src_1, src_2, opwrite, reg_write, data, rs, rt, op,
    output Instruction, DataRead, data_src_1, data_src_2, rd
  );
endinterface

// File: rtl/ctrl_seq.sv
// Four-cycle FETCH/DECODE/EXEC/WB instruction sequencer; HALT is terminal until reset.
// Strobes decode straight from the state register, so reset removes them with no glitch.
module ctrl_seq #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [1:0]  ACC_REG  = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       halted,
  ctrl_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_DIV = 3'b010;
  localparam logic [2:0] OPC_MUL = 3'b011;
  localparam logic [2:0] OPC_CLR = 3'b100;
  localparam logic [2:0] OPC_HLT = 3'b101;
  localparam logic [2:0] OPC_RD  = 3'b110;
  localparam logic [2:0] OPC_WR  = 3'b111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic [3:0]  r_op;
  logic [31:0] r_rdata;

  logic [2:0]  w_opc;
  logic [1:0]  w_fonte;
  logic [1:0]  w_dest;
  logic [31:0] w_imm;
  logic        w_arith;
  logic [3:0]  w_alu_op;

  assign w_opc   = r_ir[31:29];
  assign w_fonte = r_ir[28:27];
  assign w_dest  = r_ir[26:25];
  assign w_imm   = {7'd0, r_ir[24:0]};
  assign w_arith = ~w_opc[2];

  always_comb begin
    w_alu_op = 4'b0000;
    case (w_opc)
      OPC_ADD: w_alu_op = 4'b1000;
      OPC_SUB: w_alu_op = 4'b0100;
      OPC_DIV: w_alu_op = 4'b0001;
      OPC_MUL: w_alu_op = 4'b0010;
      default: w_alu_op = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 32'd0;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_op    <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_FETCH: begin
          if (run) r_ir <= bus.Instruction;
        end
        S_EXEC: begin
          // ALU operands are frozen here so rd stays stable while WB writes it back
          if (w_arith) begin
            r_rs <= bus.data_src_2;
            r_rt <= w_imm;
            r_op <= w_alu_op;
          end
          if (w_opc == OPC_RD) r_rdata <= bus.DataRead;
        end
        S_WB: r_pc <= r_pc + 32'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  w_state_nxt = run ? S_DECODE : S_FETCH;
      S_DECODE: w_state_nxt = (w_opc == OPC_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  assign bus.Read_PC = r_pc;
  assign halted      = (r_state == S_HALT);

  always_comb begin
    bus.Op2En     = 1'b0;
    bus.Op2RW     = 1'b0;
    bus.M_Clear   = 1'b0;
    bus.R_W_Addr  = 32'd0;
    bus.DataWrite = 32'd0;
    bus.src_1     = 2'd0;
    bus.src_2     = 2'd0;
    bus.opwrite   = 1'b0;
    bus.reg_write = 2'd0;
    bus.data      = 32'd0;
    bus.rs        = 32'd0;
    bus.rt        = 32'd0;
    bus.op        = 4'd0;
    case (r_state)
      S_DECODE: begin
        if (w_arith)         bus.src_2 = w_fonte;
        if (w_opc == OPC_WR) bus.src_1 = w_fonte;
      end
      S_EXEC: begin
        // register-file selects stay up so a combinational read still feeds EXEC
        if (w_arith) begin
          bus.src_2 = w_fonte;
          bus.rs    = bus.data_src_2;
          bus.rt    = w_imm;
          bus.op    = w_alu_op;
        end
        case (w_opc)
          OPC_RD: begin
            bus.Op2En    = 1'b1;
            bus.R_W_Addr = w_imm;
          end
          OPC_WR: begin
            bus.src_1     = w_fonte;
            bus.Op2En     = 1'b1;
            bus.Op2RW     = 1'b1;
            bus.R_W_Addr  = w_imm;
            bus.DataWrite = bus.data_src_1;
          end
          OPC_CLR: begin
            bus.M_Clear  = 1'b1;
            bus.R_W_Addr = w_imm;
          end
          default: ;
        endcase
      end
      S_WB: begin
        if (w_arith) begin
          bus.rs        = r_rs;
          bus.rt        = r_rt;
          bus.op        = r_op;
          bus.opwrite   = 1'b1;
          bus.reg_write = ACC_REG;
          bus.data      = bus.rd;
        end else if (w_opc == OPC_RD) begin
          bus.opwrite   = 1'b1;
          bus.reg_write = w_dest;
          bus.data      = r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: behavioural memories/register file/ALU around the DUT, plus a
// per-instruction trace model compared every cycle and literal checks on hand-derived values.
module tb_ctrl_seq;

  logic clk = 1'b0;
  logic rst, run, halted;
  logic rst2, run2, halted2;

  ctrl_seq_if bus();
  ctrl_seq_if bus2();

  ctrl_seq u_dut (.clk(clk), .rst(rst), .run(run), .halted(halted), .bus(bus));
  ctrl_seq #(.RESET_PC(32'hFFFF_FFFF)) u_dut2 (.clk(clk), .rst(rst2), .run(run2), .halted(halted2), .bus(bus2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment: instruction ROM, register file, data memory, ALU
  logic [31:0] imem [0:15];
  logic [31:0] regs [0:3];
  logic [31:0] dmem [0:63];
  bit          env_init = 1'b0;

  function automatic logic [31:0] env_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b1000: return a + b;
      4'b0100: return a - b;
      4'b0001: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'b0010: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.Instruction = imem[bus.Read_PC[3:0]];
  assign bus.data_src_1  = regs[bus.src_1];
  assign bus.data_src_2  = regs[bus.src_2];
  assign bus.DataRead    = dmem[bus.R_W_Addr[5:0]];
  assign bus.rd          = env_alu(bus.rs, bus.rt, bus.op);

  always @(posedge clk) begin
    if (!env_init) begin
      regs[0] <= 32'd0; regs[1] <= 32'd5; regs[2] <= 32'd0; regs[3] <= 32'd0;
      for (int i = 0; i < 64; i++) dmem[i] <= (i == 8) ? 32'h1234 : 32'd0;
      env_init <= 1'b1;
    end else begin
      if (bus.opwrite) regs[bus.reg_write] <= bus.data;
      if (bus.Op2En && bus.Op2RW) dmem[bus.R_W_Addr[5:0]] <= bus.DataWrite;
      if (bus.M_Clear) dmem[bus.R_W_Addr[5:0]] <= 32'd0;
    end
  end

  assign bus2.Instruction = {3'b000, 2'b01, 2'b00, 25'd7};
  assign bus2.data_src_1  = 32'd9;
  assign bus2.data_src_2  = 32'd9;
  assign bus2.DataRead    = 32'd0;
  assign bus2.rd          = env_alu(bus2.rs, bus2.rt, bus2.op);

  // Model: each fetched instruction expands into its whole cycle-by-cycle output trace
  typedef struct {
    logic [31:0] pc;
    logic        halted, op2en, op2rw, mclear, opwrite;
    logic [31:0] addr, dwrite, data, rs, rt;
    logic [1:0]  regw, src1, src2;
    logic [3:0]  op;
    int          eff;
    int          eidx;
    logic [31:0] eval;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mreg [0:3];
  logic [31:0] mmem [0:63];
  logic [31:0] mpc;
  bit          mhalt;
  bit          m_init = 1'b0;

  function automatic exp_t idle_vec();
    exp_t e;
    e.pc = mpc; e.halted = mhalt; e.op2en = 0; e.op2rw = 0; e.mclear = 0; e.opwrite = 0;
    e.addr = 0; e.dwrite = 0; e.data = 0; e.rs = 0; e.rt = 0;
    e.regw = 0; e.src1 = 0; e.src2 = 0; e.op = 0; e.eff = 0; e.eidx = 0; e.eval = 0;
    return e;
  endfunction

  function automatic logic [3:0] alu_code(input logic [2:0] opc);
    case (opc)
      3'd0: return 4'b1000;
      3'd1: return 4'b0100;
      3'd2: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] arith(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    case (opc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return a * b;
    endcase
  endfunction

  task automatic model_fetch();
    exp_t        e;
    logic [31:0] ins, imm, a;
    logic [2:0]  opc;
    logic [1:0]  fa, ds;
    q.push_back(idle_vec());
    if (mhalt || !run) return;
    ins = imem[mpc[3:0]];
    opc = ins[31:29]; fa = ins[28:27]; ds = ins[26:25]; imm = {7'd0, ins[24:0]};
    a = mreg[fa];
    e = idle_vec();
    if (!opc[2]) e.src2 = fa;
    if (opc == 3'd7) e.src1 = fa;
    q.push_back(e);
    if (opc == 3'd5) begin
      mhalt = 1'b1;
      return;
    end
    if (!opc[2]) begin
      e.rs = a; e.rt = imm; e.op = alu_code(opc);
    end else if (opc == 3'd6) begin
      e.op2en = 1; e.addr = imm;
    end else if (opc == 3'd7) begin
      e.op2en = 1; e.op2rw = 1; e.addr = imm; e.dwrite = a;
      e.eff = 2; e.eidx = int'(imm[5:0]); e.eval = a;
    end else begin
      e.mclear = 1; e.addr = imm; e.eff = 2; e.eidx = int'(imm[5:0]); e.eval = 0;
    end
    q.push_back(e);
    e = idle_vec();
    if (!opc[2]) begin
      e.rs = a; e.rt = imm; e.op = alu_code(opc);
      e.opwrite = 1; e.regw = 2'b10; e.data = arith(opc, a, imm);
      e.eff = 1; e.eidx = 2; e.eval = e.data;
    end else if (opc == 3'd6) begin
      e.opwrite = 1; e.regw = ds; e.data = mmem[imm[5:0]];
      e.eff = 1; e.eidx = int'(ds); e.eval = e.data;
    end
    q.push_back(e);
    mpc = mpc + 32'd1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      mpc   = 32'd0;
      mhalt = 1'b0;
      if (!m_init) begin
        mreg[0] = 0; mreg[1] = 5; mreg[2] = 0; mreg[3] = 0;
        for (int i = 0; i < 64; i++) mmem[i] = (i == 8) ? 32'h1234 : 32'd0;
        m_init = 1'b1;
      end
    end else begin
      if (q.size() == 0) model_fetch();
      e = q.pop_front();
      chk("pc",        bus.Read_PC,          e.pc);
      chk("halted",    32'(halted),          32'(e.halted));
      chk("Op2En",     32'(bus.Op2En),       32'(e.op2en));
      chk("Op2RW",     32'(bus.Op2RW),       32'(e.op2rw));
      chk("M_Clear",   32'(bus.M_Clear),     32'(e.mclear));
      chk("R_W_Addr",  bus.R_W_Addr,         e.addr);
      chk("DataWrite", bus.DataWrite,        e.dwrite);
      chk("opwrite",   32'(bus.opwrite),     32'(e.opwrite));
      chk("reg_write", 32'(bus.reg_write),   32'(e.regw));
      chk("data",      bus.data,             e.data);
      chk("rs",        bus.rs,               e.rs);
      chk("rt",        bus.rt,               e.rt);
      chk("op",        32'(bus.op),          32'(e.op));
      chk("src_1",     32'(bus.src_1),       32'(e.src1));
      chk("src_2",     32'(bus.src_2),       32'(e.src2));
      if (e.eff == 1) mreg[e.eidx] = e.eval;
      if (e.eff == 2) mmem[e.eidx] = e.eval;
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst = 1'b1; run = 1'b0; rst2 = 1'b1; run2 = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 32'd0;
    imem[0] = {3'b000, 2'b01, 2'b00, 25'd3};
    imem[1] = {3'b110, 2'b00, 2'b11, 25'd8};
    imem[2] = {3'b011, 2'b01, 2'b00, 25'd6};
    imem[3] = {3'b111, 2'b10, 2'b00, 25'd11};
    imem[4] = {3'b101, 29'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc",      bus.Read_PC, 32'd0);
    chk("rst_halted",  32'(halted), 32'd0);
    chk("rst_strobes", {29'd0, bus.Op2En, bus.M_Clear, bus.opwrite}, 32'd0);
    chk("rst_addr",    bus.R_W_Addr, 32'd0);
    chk("rst_op",      32'(bus.op), 32'd0);
    chk("rst_pc2",     bus2.Read_PC, 32'hFFFF_FFFF);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc",      bus.Read_PC, 32'd0);
      chk("stall_strobes", {29'd0, bus.Op2En, bus.M_Clear, bus.opwrite}, 32'd0);
    end
    @(posedge clk); #1 run = 1'b1;

    negs(3);
    chk("add_rs", bus.rs, 32'd5);
    chk("add_rt", bus.rt, 32'd3);
    chk("add_op", 32'(bus.op), 32'h8);
    negs(1);
    chk("add_opwrite", 32'(bus.opwrite), 32'd1);
    chk("add_regw",    32'(bus.reg_write), 32'd2);
    chk("add_data",    bus.data, 32'd8);
    negs(1);
    chk("add_pc_next", bus.Read_PC, 32'd1);
    negs(2);
    chk("rd_en",   32'(bus.Op2En), 32'd1);
    chk("rd_rw",   32'(bus.Op2RW), 32'd0);
    chk("rd_addr", bus.R_W_Addr, 32'd8);
    negs(1);
    chk("rd_regw", 32'(bus.reg_write), 32'd3);
    chk("rd_data", bus.data, 32'h1234);
    negs(7);
    chk("wr_en",    32'(bus.Op2En), 32'd1);
    chk("wr_rw",    32'(bus.Op2RW), 32'd1);
    chk("wr_addr",  bus.R_W_Addr, 32'd11);
    chk("wr_dwrite", bus.DataWrite, 32'h1E);
    negs(1);
    chk("wr_no_opwrite", 32'(bus.opwrite), 32'd0);
    negs(3);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc",   bus.Read_PC, 32'd4);
    for (int i = 0; i < 20; i++) begin
      negs(1);
      chk("halt_hold_pc",  bus.Read_PC, 32'd4);
      chk("halt_strobes",  {29'd0, bus.Op2En, bus.M_Clear, bus.opwrite}, 32'd0);
    end

    // Second program: sub, div, divide by zero, clear, read-back, then a store aborted by reset
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 16; i++) imem[i] = 32'd0;
    imem[0] = {3'b001, 2'b11, 2'b01, 25'd4};
    imem[1] = {3'b010, 2'b10, 2'b00, 25'h10};
    imem[2] = {3'b010, 2'b01, 2'b00, 25'd0};
    imem[3] = {3'b100, 2'b00, 2'b00, 25'd8};
    imem[4] = {3'b110, 2'b00, 2'b01, 25'd8};
    imem[5] = {3'b111, 2'b01, 2'b00, 25'd20};
    #1;
    chk("rst_halt_clear", 32'(halted), 32'd0);
    chk("rst_pc_reload",  bus.Read_PC, 32'd0);
    @(posedge clk); #1 rst = 1'b0; run = 1'b1;

    found = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1 run = (c % 3 != 1);
      @(negedge clk);
      if (bus.Op2En && bus.Op2RW) begin
        found = 1'b1;
        break;
      end
    end
    chk("store_seen", 32'(found), 32'd1);
    chk("store_pc",     bus.Read_PC, 32'd5);
    chk("store_dwrite", bus.DataWrite, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_op2en", 32'(bus.Op2En), 32'd0);
    chk("abort_rw",    32'(bus.Op2RW), 32'd0);
    chk("abort_pc",    bus.Read_PC, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; run = 1'b1;
    negs(12);

    // Wrap-around instance: add executes from PC 0xFFFFFFFF
    @(posedge clk); #1 rst2 = 1'b0; run2 = 1'b1;
    negs(1);
    chk("wrap_pc0", bus2.Read_PC, 32'hFFFF_FFFF);
    negs(2);
    chk("wrap_rs", bus2.rs, 32'd9);
    chk("wrap_rt", bus2.rt, 32'd7);
    negs(1);
    chk("wrap_opwrite", 32'(bus2.opwrite), 32'd1);
    chk("wrap_data",    bus2.data, 32'd16);
    chk("wrap_regw",    32'(bus2.reg_write), 32'd2);
    negs(1);
    chk("wrap_pc1", bus2.Read_PC, 32'd0);
    chk("wrap_halted", 32'(halted2), 32'd0);
    run2 = 1'b0;
    negs(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
